i2c_cmd_queue: RTL and testbench

- Upstream sequencer for the I2C master: buffers host-issued I2C transactions (from the FPGA host-interface endpoints) in a command FIFO.
- Issues them one at a time over the master's rw/addr/wr_data/valid/stall interface.
- Collects read results (rd_data/rd_valid) into a response FIFO for the host to drain.
- Adds a per-transaction watchdog so a hung bus cannot wedge the host.

---
 rtl/i2c_cmd_queue.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_cmd_queue.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_queue.sv
// Show-ahead synchronous FIFO used for both the command and response queues.
// Latency: a pushed entry is visible at head_dat on the cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; clr empties in one cycle.
module i2c_cmd_queue_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  clr,
    input  logic                  push,
    input  logic [W-1:0]          push_dat,
    input  logic                  pop,
    output logic [W-1:0]          head_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Storage array; no reset needed because level gates every read.
    always_ff @(posedge hclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// Queues host I2C transactions, issues them one at a time to the master, collects read data.
// Latency: 1 IDLE cycle + 1 ISSUE cycle from a queued head to m_valid; responses show-ahead next cycle.
// Backpressure: cmd_full drops extra pushes; reads hold in IDLE until a response slot is guaranteed.
module i2c_cmd_queue #(
    parameter int CMD_DEPTH_LOG2 = 4,
    parameter int RSP_DEPTH_LOG2 = 4,
    parameter int TIMEOUT_CYC    = 65535
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      soft_clear,
    input  logic                      cmd_push,
    input  logic                      cmd_rw,
    input  logic [31:0]               cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      cmd_full,
    output logic [CMD_DEPTH_LOG2:0]   cmd_level,
    input  logic                      rsp_pop,
    output logic [31:0]               rsp_data,
    output logic                      rsp_empty,
    output logic [RSP_DEPTH_LOG2:0]   rsp_level,
    output logic                      m_rw,
    output logic [31:0]               m_addr,
    output logic [31:0]               m_wr_data,
    output logic                      m_valid,
    input  logic                      m_stall,
    input  logic [31:0]               m_rd_data,
    input  logic                      m_rd_valid,
    output logic                      busy,
    output logic                      err_timeout,
    output logic [15:0]               txn_done_cnt
);
    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int RSP_DEPTH = 1 << RSP_DEPTH_LOG2;
    localparam logic [RSP_DEPTH_LOG2+1:0] RSP_CAP = (RSP_DEPTH_LOG2+2)'(RSP_DEPTH);
    localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT_CYC - 1);

    state_t  state;
    state_t  state_nxt;
    cmd_t    cmd_in;
    cmd_t    cmd_head;
    logic    cmd_empty;
    logic    cmd_pop;
    logic    rsp_full;
    logic    rsp_push;
    logic    rd_inflight;
    logic    read_room;
    logic    timeout_hit;
    logic    txn_done;
    logic    in_wait;
    logic [19:0] wdog;
    logic [RSP_DEPTH_LOG2+1:0] rsp_commit;

    assign cmd_in = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

    i2c_cmd_queue_fifo #(
        .W          ($bits(cmd_t)),
        .DEPTH_LOG2 (CMD_DEPTH_LOG2)
    ) u_cmd_fifo (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .clr      (soft_clear),
        .push     (cmd_push),
        .push_dat (cmd_in),
        .pop      (cmd_pop),
        .head_dat (cmd_head),
        .full     (cmd_full),
        .empty    (cmd_empty),
        .level    (cmd_level)
    );

    // Late read data after a timeout is still accepted whenever a slot is free.
    assign rsp_push = m_rd_valid & ~rsp_full;

    i2c_cmd_queue_fifo #(
        .W          (32),
        .DEPTH_LOG2 (RSP_DEPTH_LOG2)
    ) u_rsp_fifo (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .clr      (soft_clear),
        .push     (rsp_push),
        .push_dat (m_rd_data),
        .pop      (rsp_pop),
        .head_dat (rsp_data),
        .full     (rsp_full),
        .empty    (rsp_empty),
        .level    (rsp_level)
    );

    // A read may only issue if its response (plus any still-outstanding read) is guaranteed a slot.
    assign rsp_commit = {1'b0, rsp_level} + (RSP_DEPTH_LOG2+2)'(rd_inflight);
    assign read_room  = (rsp_commit < RSP_CAP);
    assign in_wait    = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign busy       = (state != IDLE) || ~cmd_empty;

    // Next-state: issue guard, accept, stall handshake and watchdog abort.
    always_comb begin
        state_nxt   = state;
        cmd_pop     = 1'b0;
        timeout_hit = 1'b0;
        txn_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !m_stall && (cmd_head.rw || read_room)) begin
                    state_nxt = ISSUE;
                    cmd_pop   = 1'b1;
                end
            end
            ISSUE: begin
                if (!m_stall) begin
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Stall rising completes nothing, so the watchdog wins here.
                if (wdog >= WDOG_LAST) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end else if (m_stall) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A completion on the watchdog's last cycle still counts as done.
                if (!m_stall) begin
                    state_nxt = IDLE;
                    txn_done  = 1'b1;
                end else if (wdog >= WDOG_LAST) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, master-side registers, watchdog and status counters.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state        <= IDLE;
            m_valid      <= 1'b0;
            m_rw         <= 1'b0;
            m_addr       <= '0;
            m_wr_data    <= '0;
            err_timeout  <= 1'b0;
            txn_done_cnt <= '0;
            wdog         <= '0;
            rd_inflight  <= 1'b0;
        end else if (soft_clear) begin
            state        <= IDLE;
            m_valid      <= 1'b0;
            m_rw         <= 1'b0;
            m_addr       <= '0;
            m_wr_data    <= '0;
            err_timeout  <= 1'b0;
            txn_done_cnt <= '0;
            wdog         <= '0;
            rd_inflight  <= 1'b0;
        end else begin
            state   <= state_nxt;
            m_valid <= (state_nxt == ISSUE);
            if (cmd_pop) begin
                m_rw      <= cmd_head.rw;
                m_addr    <= cmd_head.addr;
                m_wr_data <= cmd_head.wdata;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
            if (txn_done) begin
                txn_done_cnt <= txn_done_cnt + 1'b1;
            end
            if (in_wait && (state_nxt == WAIT_BUSY || state_nxt == WAIT_DONE)) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
            // A timed-out read keeps its slot reserved until its late data shows up.
            if (state == ISSUE && state_nxt == WAIT_BUSY && !m_rw) begin
                rd_inflight <= 1'b1;
            end
            if (m_rd_valid || txn_done) begin
                rd_inflight <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_cmd_queue.sv
module tb_i2c_cmd_queue;
    localparam int CL = 4;
    localparam int RL = 4;
    localparam int TO = 100;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        soft_clear;
    logic        cmd_push;
    logic        cmd_rw;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_full;
    logic [CL:0] cmd_level;
    logic        rsp_pop;
    logic [31:0] rsp_data;
    logic        rsp_empty;
    logic [RL:0] rsp_level;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_wr_data;
    logic        m_valid;
    logic        m_stall;
    logic [31:0] m_rd_data;
    logic        m_rd_valid;
    logic        busy;
    logic        err_timeout;
    logic [15:0] txn_done_cnt;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] rd_script[$];

    int n_cmp = 0;
    int n_err = 0;
    int issued = 0;
    int exp_done = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int vlen = 0;
    int stall_fix = 0;
    int stall_max = 8;
    int pop_req = 0;
    bit force_stall = 0;
    bit hang = 0;
    bit drain_en = 0;
    bit pop_force = 0;
    bit mst_busy = 0;

    i2c_cmd_queue #(
        .CMD_DEPTH_LOG2 (CL),
        .RSP_DEPTH_LOG2 (RL),
        .TIMEOUT_CYC    (TO)
    ) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .soft_clear   (soft_clear),
        .cmd_push     (cmd_push),
        .cmd_rw       (cmd_rw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_full     (cmd_full),
        .cmd_level    (cmd_level),
        .rsp_pop      (rsp_pop),
        .rsp_data     (rsp_data),
        .rsp_empty    (rsp_empty),
        .rsp_level    (rsp_level),
        .m_rw         (m_rw),
        .m_addr       (m_addr),
        .m_wr_data    (m_wr_data),
        .m_valid      (m_valid),
        .m_stall      (m_stall),
        .m_rd_data    (m_rd_data),
        .m_rd_valid   (m_rd_valid),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .txn_done_cnt (txn_done_cnt)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Master model: accepts when valid & !stall, raises stall the cycle after, returns read data.
    initial begin : master
        logic rw;
        int   n;
        logic [31:0] d;
        m_stall = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data = '0;
        forever begin
            @(posedge hclk); #1;
            if (m_valid && !m_stall && hresetn) begin
                rw = m_rw;
                mst_busy = 1'b1;
                @(posedge hclk); #1;
                acc_cyc = cyc;
                m_stall = 1'b1;
                if (hang) begin
                    while (hang) begin
                        @(posedge hclk); #1;
                    end
                end else begin
                    n = (stall_fix != 0) ? stall_fix : $urandom_range(1, stall_max);
                    for (int k = 1; k <= n; k++) begin
                        if (k == n && !rw) begin
                            d = (rd_script.size() != 0) ? rd_script.pop_front() : $urandom;
                            m_rd_valid = 1'b1;
                            m_rd_data = d;
                            exp_rsp.push_back(d);
                        end
                        @(posedge hclk); #1;
                        m_rd_valid = 1'b0;
                    end
                    exp_done++;
                end
                m_stall = 1'b0;
                mst_busy = 1'b0;
            end else begin
                m_stall = force_stall;
            end
        end
    end

    // Issue monitor: every m_valid pulse must match the next queued command and last one cycle.
    always @(negedge hclk) begin : issue_mon
        cmd_t e;
        if (m_valid) begin
            vlen++;
            if (vlen == 1) begin
                issued++;
                check("issue_expected", longint'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0) begin
                    e = exp_cmd.pop_front();
                    check("issue_rw", longint'(m_rw), longint'(e.rw));
                    check("issue_addr", longint'(m_addr), longint'(e.addr));
                    check("issue_wdata", longint'(m_wr_data), longint'(e.wdata));
                end
            end
        end else begin
            if (vlen != 0) check("m_valid_width", longint'(vlen), 1);
            vlen = 0;
        end
    end

    // Response drain and monitor: each popped word must be the oldest expected response.
    initial begin : drain
        rsp_pop = 1'b0;
        forever begin
            @(negedge hclk);
            rsp_pop = 1'b0;
            if (pop_force) begin
                rsp_pop = 1'b1;
            end else if (!rsp_empty && (pop_req > 0 || (drain_en && $urandom_range(0, 1) == 1))) begin
                if (pop_req > 0) pop_req--;
                check("rsp_expected", longint'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) check("rsp_data", longint'(rsp_data), longint'(exp_rsp.pop_front()));
                rsp_pop = 1'b1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge hclk);
    endtask

    task automatic push(input logic rw, input logic [31:0] a, input logic [31:0] d, input bit acc);
        @(negedge hclk);
        cmd_push = 1'b1;
        cmd_rw = rw;
        cmd_addr = a;
        cmd_wdata = d;
        if (acc) exp_cmd.push_back('{rw: rw, addr: a, wdata: d});
        @(negedge hclk);
        cmd_push = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int k = 0;
        while ((busy || mst_busy) && k < budget) begin
            @(negedge hclk);
            k++;
        end
        check("quiet_reached", longint'(busy || mst_busy), 0);
    endtask

    task automatic wait_rsp_empty(input int budget);
        int k = 0;
        while (!rsp_empty && k < budget) begin
            @(negedge hclk);
            k++;
        end
        cycles(1);
        check("rsp_drained", longint'(rsp_empty), 1);
    endtask

    task automatic do_soft_clear();
        @(negedge hclk);
        soft_clear = 1'b1;
        @(negedge hclk);
        soft_clear = 1'b0;
        check("clr_txn_cnt", longint'(txn_done_cnt), 0);
        check("clr_err", longint'(err_timeout), 0);
    endtask

    initial begin : main
        int base;
        int pushed;
        int err_cyc;
        int k;
        hresetn = 1'b0;
        soft_clear = 1'b0;
        cmd_push = 1'b0;
        cmd_rw = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cycles(3);
        check("rst_cmd_level", longint'(cmd_level), 0);
        check("rst_cmd_full", longint'(cmd_full), 0);
        check("rst_rsp_empty", longint'(rsp_empty), 1);
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_txn_cnt", longint'(txn_done_cnt), 0);
        hresetn = 1'b1;
        cycles(2);

        // Single write, 40-cycle stall.
        stall_fix = 40;
        base = issued;
        push(1'b1, 32'h10, 32'hA5, 1'b1);
        wait_quiet(300);
        check("t1_issued", longint'(issued - base), 1);
        check("t1_txn_cnt", longint'(txn_done_cnt), 1);
        check("t1_rsp_empty", longint'(rsp_empty), 1);
        stall_fix = 0;
        do_soft_clear();

        // Three reads with scripted data, drained in order.
        force_stall = 1'b1;
        cycles(2);
        rd_script.push_back(32'h11);
        rd_script.push_back(32'h22);
        rd_script.push_back(32'h33);
        for (int i = 0; i < 3; i++) push(1'b0, 32'h100 + 32'(i), $urandom, 1'b1);
        check("t2_cmd_level_3", longint'(cmd_level), 3);
        force_stall = 1'b0;
        wait_quiet(300);
        check("t2_cmd_level_0", longint'(cmd_level), 0);
        check("t2_txn_cnt", longint'(txn_done_cnt), 3);
        check("t2_rsp_level", longint'(rsp_level), 3);
        pop_req = 3;
        wait_rsp_empty(50);
        check("t2_rsp_all_seen", longint'(exp_rsp.size()), 0);
        pop_force = 1'b1;
        cycles(3);
        pop_force = 1'b0;
        cycles(1);
        check("empty_pop_level", longint'(rsp_level), 0);
        do_soft_clear();

        // Response FIFO filled: the 17th read must wait for a pop.
        base = issued;
        stall_max = 3;
        for (int i = 0; i < 16; i++) push(1'b0, $urandom, $urandom, 1'b1);
        wait_quiet(1000);
        check("t3_rsp_level_full", longint'(rsp_level), 16);
        push(1'b0, 32'hBEEF, 32'h0, 1'b1);
        cycles(20);
        check("t3_read_blocked", longint'(issued - base), 16);
        check("t3_blocked_level", longint'(cmd_level), 1);
        check("t3_blocked_busy", longint'(busy), 1);
        pop_req = 1;
        wait_quiet(200);
        check("t3_read_released", longint'(issued - base), 17);
        check("t3_txn_cnt", longint'(txn_done_cnt), 17);
        check("t3_rsp_level_refill", longint'(rsp_level), 16);
        drain_en = 1'b1;
        wait_rsp_empty(500);
        drain_en = 1'b0;
        do_soft_clear();

        // Command FIFO filled: the 17th push is dropped.
        base = issued;
        force_stall = 1'b1;
        cycles(2);
        for (int i = 0; i < 16; i++) push(1'b1, $urandom, $urandom, 1'b1);
        push(1'b1, 32'hDEAD, 32'hDEAD, 1'b0);
        check("t4_cmd_full", longint'(cmd_full), 1);
        check("t4_cmd_level", longint'(cmd_level), 16);
        force_stall = 1'b0;
        wait_quiet(2000);
        check("t4_issued", longint'(issued - base), 16);
        check("t4_txn_cnt", longint'(txn_done_cnt), 16);
        check("t4_cmd_empty_level", longint'(cmd_level), 0);
        do_soft_clear();

        // Watchdog: master hangs with stall high.
        base = issued;
        hang = 1'b1;
        push(1'b1, 32'h55, 32'h66, 1'b1);
        k = 0;
        err_cyc = 0;
        while (k < 400 && err_cyc == 0) begin
            @(posedge hclk); #1;
            if (err_timeout) err_cyc = cyc;
            k++;
        end
        check("t5_timeout_cycle", longint'(err_cyc - acc_cyc), TO);
        cycles(2);
        check("t5_idle_after_timeout", longint'(busy), 0);
        push(1'b1, 32'h77, 32'h88, 1'b1);
        cycles(10);
        check("t5_held_by_stall", longint'(issued - base), 1);
        hang = 1'b0;
        wait_quiet(300);
        check("t5_next_issued", longint'(issued - base), 2);
        check("t5_txn_cnt", longint'(txn_done_cnt), 1);
        check("t5_err_sticky", longint'(err_timeout), 1);
        do_soft_clear();

        // Randomized traffic against the queue model.
        exp_done = 0;
        base = issued;
        pushed = 0;
        stall_max = 20;
        drain_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            k = 0;
            while (pushed - (issued - base) >= 8 && k < 2000) begin
                cycles(1);
                k++;
            end
            push(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
            pushed++;
            cycles($urandom_range(0, 3));
        end
        wait_quiet(3000);
        wait_rsp_empty(500);
        drain_en = 1'b0;
        check("t6_issued", longint'(issued - base), 60);
        check("t6_txn_cnt", longint'(txn_done_cnt), longint'(exp_done));
        check("t6_cmd_leftover", longint'(exp_cmd.size()), 0);
        check("t6_rsp_leftover", longint'(exp_rsp.size()), 0);
        do_soft_clear();

        // Async reset in the middle of a long transaction with 5 queued.
        stall_fix = 40;
        for (int i = 0; i < 6; i++) push(1'b1, 32'(i), $urandom, 1'b1);
        cycles(5);
        check("t7_queued", longint'(cmd_level), 5);
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        check("t7_rst_m_valid", longint'(m_valid), 0);
        check("t7_rst_m_addr", longint'(m_addr), 0);
        check("t7_rst_m_wr_data", longint'(m_wr_data), 0);
        check("t7_rst_cmd_level", longint'(cmd_level), 0);
        check("t7_rst_busy", longint'(busy), 0);
        exp_cmd.delete();
        cycles(2);
        hresetn = 1'b1;
        base = issued;
        k = 0;
        while (mst_busy && k < 200) begin
            cycles(1);
            k++;
        end
        stall_fix = 0;
        cycles(50);
        check("t7_no_issue_after", longint'(issued - base), 0);
        check("t7_txn_cnt", longint'(txn_done_cnt), 0);
        check("t7_cmd_level", longint'(cmd_level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : guard
        #500000;
        n_err++;
        $display("FAIL global_time_limit: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end
endmodule
